rf_read_resp_collector: RTL and testbench

- Return path of the four-bank register-file request dispatcher.
- Each cycle it accepts up to four bank read responses, each tagged with the 4-bit ocid that travelled with its request.
- It steers the 256-bit data into the owning operand-collector (OC) slot's src1/src2 register and tracks per-slot operand completion.
- Completed slots are handed to the execute stage through a valid/ready handshake, with round-robin selection among ready slots.

---
 rtl/rf_read_resp_collector.sv | 238 +++++++++++++++++++++++
 tb/tb_rf_read_resp_collector.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_read_resp_collector.sv
// Operand collector return path: steers up to four bank read responses into
// per-slot src1/src2 registers, tracks completion, and hands finished slots to
// execute with round-robin selection and a stable presentation while stalled.
module rf_read_resp_collector #(
    parameter int unsigned NUM_OC   = 8,
    parameter int unsigned DATA_W   = 256,
    parameter int unsigned NUM_BANK = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alloc_valid,
    input  logic [$clog2(NUM_OC)-1:0]  alloc_ocid,
    input  logic                       alloc_src1_need,
    input  logic                       alloc_src2_need,
    input  logic                       rd_valid_0,
    input  logic [$clog2(NUM_OC):0]    rd_ocid_0,
    input  logic [DATA_W-1:0]          rd_data_0,
    input  logic                       rd_valid_1,
    input  logic [$clog2(NUM_OC):0]    rd_ocid_1,
    input  logic [DATA_W-1:0]          rd_data_1,
    input  logic                       rd_valid_2,
    input  logic [$clog2(NUM_OC):0]    rd_ocid_2,
    input  logic [DATA_W-1:0]          rd_data_2,
    input  logic                       rd_valid_3,
    input  logic [$clog2(NUM_OC):0]    rd_ocid_3,
    input  logic [DATA_W-1:0]          rd_data_3,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(NUM_OC)-1:0]  out_ocid,
    output logic [DATA_W-1:0]          out_src1,
    output logic [DATA_W-1:0]          out_src2,
    output logic [NUM_OC-1:0]          slot_busy,
    output logic                       err
);

    localparam int unsigned IDX_W = $clog2(NUM_OC);
    localparam int unsigned TAG_W = IDX_W + 1;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2
    } slot_state_e;

    slot_state_e       state_q [NUM_OC];
    logic [NUM_OC-1:0] need1_q;
    logic [NUM_OC-1:0] need2_q;
    logic [NUM_OC-1:0] have1_q;
    logic [NUM_OC-1:0] have2_q;
    logic [DATA_W-1:0] src1_q [NUM_OC];
    logic [DATA_W-1:0] src2_q [NUM_OC];
    logic [IDX_W-1:0]  rr_ptr_q;
    logic              hold_valid_q;
    logic [IDX_W-1:0]  hold_idx_q;
    logic              err_q;

    logic              rsp_valid [NUM_BANK];
    logic [TAG_W-1:0]  rsp_tag   [NUM_BANK];
    logic [DATA_W-1:0] rsp_data  [NUM_BANK];

    logic [NUM_OC-1:0] wr1_en;
    logic [NUM_OC-1:0] wr2_en;
    logic [DATA_W-1:0] wr1_data [NUM_OC];
    logic [DATA_W-1:0] wr2_data [NUM_OC];
    logic [2:0]        cnt1;
    logic [2:0]        cnt2;
    logic              resp_err;

    logic [NUM_OC-1:0] alloc_hit;
    logic              alloc_err;

    logic              sel_found;
    logic [IDX_W-1:0]  sel_idx;
    logic [IDX_W-1:0]  cand;
    logic              fire;

    // Gather the bank ports into arrays so the decode can loop over them
    assign rsp_valid[0] = rd_valid_0;
    assign rsp_valid[1] = rd_valid_1;
    assign rsp_valid[2] = rd_valid_2;
    assign rsp_valid[3] = rd_valid_3;
    assign rsp_tag[0]   = rd_ocid_0;
    assign rsp_tag[1]   = rd_ocid_1;
    assign rsp_tag[2]   = rd_ocid_2;
    assign rsp_tag[3]   = rd_ocid_3;
    assign rsp_data[0]  = rd_data_0;
    assign rsp_data[1]  = rd_data_1;
    assign rsp_data[2]  = rd_data_2;
    assign rsp_data[3]  = rd_data_3;

    // Per slot/operand: count hitting ports; accept only a single legal hit
    always_comb begin
        wr1_en   = '0;
        wr2_en   = '0;
        resp_err = 1'b0;
        cnt1     = '0;
        cnt2     = '0;
        for (int s = 0; s < NUM_OC; s++) begin
            wr1_data[s] = '0;
            wr2_data[s] = '0;
        end
        for (int s = 0; s < NUM_OC; s++) begin
            cnt1 = '0;
            cnt2 = '0;
            for (int b = 0; b < NUM_BANK; b++) begin
                if (rsp_valid[b] && (rsp_tag[b][IDX_W-1:0] == IDX_W'(s))) begin
                    if (rsp_tag[b][IDX_W]) begin
                        cnt2        = cnt2 + 3'd1;
                        wr2_data[s] = rsp_data[b];
                    end else begin
                        cnt1        = cnt1 + 3'd1;
                        wr1_data[s] = rsp_data[b];
                    end
                end
            end
            wr1_en[s] = (cnt1 == 3'd1) && (state_q[s] == S_WAIT) && need1_q[s] && !have1_q[s];
            wr2_en[s] = (cnt2 == 3'd1) && (state_q[s] == S_WAIT) && need2_q[s] && !have2_q[s];
            if (((cnt1 != 3'd0) && !wr1_en[s]) || ((cnt2 != 3'd0) && !wr2_en[s])) begin
                resp_err = 1'b1;
            end
        end
    end

    // Allocation is legal only into a slot that is empty at the start of the cycle
    always_comb begin
        alloc_hit = '0;
        alloc_err = 1'b0;
        if (alloc_valid) begin
            if (state_q[alloc_ocid] == S_EMPTY) begin
                alloc_hit[alloc_ocid] = 1'b1;
            end else begin
                alloc_err = 1'b1;
            end
        end
    end

    // Round-robin pick among READY slots; a stalled presentation stays locked
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        if (hold_valid_q) begin
            sel_found = 1'b1;
            sel_idx   = hold_idx_q;
        end else begin
            for (int unsigned k = 0; k < NUM_OC; k++) begin
                cand = IDX_W'((32'(rr_ptr_q) + k) % NUM_OC);
                if (!sel_found && (state_q[cand] == S_READY)) begin
                    sel_found = 1'b1;
                    sel_idx   = cand;
                end
            end
        end
    end

    assign fire = sel_found && out_ready;

    // Slot state machines, operand capture, RR pointer, stall lock and sticky error
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < NUM_OC; s++) begin
                state_q[s] <= S_EMPTY;
                src1_q[s]  <= '0;
                src2_q[s]  <= '0;
            end
            need1_q      <= '0;
            need2_q      <= '0;
            have1_q      <= '0;
            have2_q      <= '0;
            rr_ptr_q     <= '0;
            hold_valid_q <= 1'b0;
            hold_idx_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            for (int s = 0; s < NUM_OC; s++) begin
                case (state_q[s])
                    S_EMPTY: begin
                        if (alloc_hit[s]) begin
                            need1_q[s] <= alloc_src1_need;
                            need2_q[s] <= alloc_src2_need;
                            have1_q[s] <= 1'b0;
                            have2_q[s] <= 1'b0;
                            state_q[s] <= (alloc_src1_need || alloc_src2_need) ? S_WAIT : S_READY;
                        end
                    end
                    S_WAIT: begin
                        if (wr1_en[s]) begin
                            src1_q[s]  <= wr1_data[s];
                            have1_q[s] <= 1'b1;
                        end
                        if (wr2_en[s]) begin
                            src2_q[s]  <= wr2_data[s];
                            have2_q[s] <= 1'b1;
                        end
                        if ((!need1_q[s] || have1_q[s] || wr1_en[s]) &&
                            (!need2_q[s] || have2_q[s] || wr2_en[s])) begin
                            state_q[s] <= S_READY;
                        end
                    end
                    S_READY: begin
                        if (fire && (sel_idx == IDX_W'(s))) begin
                            state_q[s] <= S_EMPTY;
                            src1_q[s]  <= '0;
                            src2_q[s]  <= '0;
                            need1_q[s] <= 1'b0;
                            need2_q[s] <= 1'b0;
                            have1_q[s] <= 1'b0;
                            have2_q[s] <= 1'b0;
                        end
                    end
                    default: state_q[s] <= S_EMPTY;
                endcase
            end
            if (fire) begin
                rr_ptr_q <= sel_idx + IDX_W'(1);
            end
            hold_valid_q <= sel_found && !out_ready;
            hold_idx_q   <= sel_idx;
            if (resp_err || alloc_err) begin
                err_q <= 1'b1;
            end
        end
    end

    // Presentation muxes and busy vector straight from slot registers
    always_comb begin
        out_valid = sel_found;
        out_ocid  = sel_found ? sel_idx : '0;
        out_src1  = sel_found ? src1_q[sel_idx] : '0;
        out_src2  = sel_found ? src2_q[sel_idx] : '0;
        err       = err_q;
        slot_busy = '0;
        for (int s = 0; s < NUM_OC; s++) begin
            slot_busy[s] = (state_q[s] != S_EMPTY);
        end
    end

endmodule

// File: tb/tb_rf_read_resp_collector.sv
// Bench for rf_read_resp_collector: directed scenarios plus randomized traffic
// checked against a slot-level behavioural model.
module tb_rf_read_resp_collector;

    localparam int unsigned NUM_OC = 8;
    localparam int unsigned DATA_W = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              alloc_valid;
    logic [2:0]        alloc_ocid;
    logic              alloc_src1_need;
    logic              alloc_src2_need;
    logic              rv   [4];
    logic [3:0]        ro   [4];
    logic [DATA_W-1:0] rdat [4];
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        out_ocid;
    logic [DATA_W-1:0] out_src1;
    logic [DATA_W-1:0] out_src2;
    logic [7:0]        slot_busy;
    logic              err;

    int tests = 0;
    int fails = 0;

    // Reference model: a slot is ready when allocated and every needed operand is had
    bit                m_alloc [NUM_OC];
    bit                m_n1    [NUM_OC];
    bit                m_n2    [NUM_OC];
    bit                m_h1    [NUM_OC];
    bit                m_h2    [NUM_OC];
    logic [DATA_W-1:0] m_d1    [NUM_OC];
    logic [DATA_W-1:0] m_d2    [NUM_OC];
    int                m_ptr;
    int                m_lock;
    bit                m_err;

    always #5 clk = ~clk;

    rf_read_resp_collector dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_valid     (alloc_valid),
        .alloc_ocid      (alloc_ocid),
        .alloc_src1_need (alloc_src1_need),
        .alloc_src2_need (alloc_src2_need),
        .rd_valid_0      (rv[0]),
        .rd_ocid_0       (ro[0]),
        .rd_data_0       (rdat[0]),
        .rd_valid_1      (rv[1]),
        .rd_ocid_1       (ro[1]),
        .rd_data_1       (rdat[1]),
        .rd_valid_2      (rv[2]),
        .rd_ocid_2       (ro[2]),
        .rd_data_2       (rdat[2]),
        .rd_valid_3      (rv[3]),
        .rd_ocid_3       (ro[3]),
        .rd_data_3       (rdat[3]),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_ocid        (out_ocid),
        .out_src1        (out_src1),
        .out_src2        (out_src2),
        .slot_busy       (slot_busy),
        .err             (err)
    );

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic bit m_ready(int s);
        return m_alloc[s] && (!m_n1[s] || m_h1[s]) && (!m_n2[s] || m_h2[s]);
    endfunction

    function automatic int m_sel();
        if (m_lock >= 0) return m_lock;
        for (int k = 0; k < NUM_OC; k++) begin
            if (m_ready((m_ptr + k) % NUM_OC)) return (m_ptr + k) % NUM_OC;
        end
        return -1;
    endfunction

    function automatic logic [7:0] m_busy();
        logic [7:0] v;
        for (int s = 0; s < NUM_OC; s++) v[s] = m_alloc[s];
        return v;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NUM_OC; s++) begin
            m_alloc[s] = 0; m_n1[s] = 0; m_n2[s] = 0; m_h1[s] = 0; m_h2[s] = 0;
            m_d1[s] = '0; m_d2[s] = '0;
        end
        m_ptr = 0; m_lock = -1; m_err = 0;
    endtask

    // Apply one clock edge to the model using the inputs currently driven
    task automatic model_edge();
        int                sel;
        int                cnt [NUM_OC][2];
        logic [DATA_W-1:0] d   [NUM_OC][2];
        bit                rdy [NUM_OC];
        int                s;
        int                o;
        if (!rst) begin
            model_reset();
            return;
        end
        sel = m_sel();
        for (int i = 0; i < NUM_OC; i++) begin
            rdy[i] = m_ready(i);
            cnt[i][0] = 0; cnt[i][1] = 0; d[i][0] = '0; d[i][1] = '0;
        end
        for (int b = 0; b < 4; b++) begin
            if (rv[b]) begin
                s = int'(ro[b][2:0]);
                o = int'(ro[b][3]);
                cnt[s][o] = cnt[s][o] + 1;
                d[s][o] = rdat[b];
            end
        end
        for (int i = 0; i < NUM_OC; i++) begin
            if (cnt[i][0] > 0) begin
                if (cnt[i][0] == 1 && m_alloc[i] && !rdy[i] && m_n1[i] && !m_h1[i]) begin
                    m_h1[i] = 1; m_d1[i] = d[i][0];
                end else m_err = 1;
            end
            if (cnt[i][1] > 0) begin
                if (cnt[i][1] == 1 && m_alloc[i] && !rdy[i] && m_n2[i] && !m_h2[i]) begin
                    m_h2[i] = 1; m_d2[i] = d[i][1];
                end else m_err = 1;
            end
        end
        if (alloc_valid) begin
            s = int'(alloc_ocid);
            if (m_alloc[s]) m_err = 1;
            else begin
                m_alloc[s] = 1; m_n1[s] = alloc_src1_need; m_n2[s] = alloc_src2_need;
                m_h1[s] = 0; m_h2[s] = 0; m_d1[s] = '0; m_d2[s] = '0;
            end
        end
        if (sel >= 0 && out_ready) begin
            m_alloc[sel] = 0; m_d1[sel] = '0; m_d2[sel] = '0;
            m_ptr = (sel + 1) % NUM_OC;
            m_lock = -1;
        end else begin
            m_lock = sel;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive_idle();
        alloc_valid = 0; alloc_ocid = '0; alloc_src1_need = 0; alloc_src2_need = 0;
        for (int b = 0; b < 4; b++) begin
            rv[b] = 0; ro[b] = '0; rdat[b] = '0;
        end
    endtask

    task automatic do_reset();
        rst = 0;
        step();
        rst = 1;
    endtask

    task automatic test_reset();
        drive_idle();
        out_ready = 0;
        rst = 0;
        step();
        step();
        rst = 1;
        repeat (5) step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        tests++; if (slot_busy !== 8'h00) begin fails++; $display("FAIL reset_busy got %h exp 00", slot_busy); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", err); end
        tests++; if (out_ocid !== 3'd0) begin fails++; $display("FAIL reset_ocid got %0d exp 0", out_ocid); end
        tests++; if (out_src1 !== '0) begin fails++; $display("FAIL reset_src1 got %h exp 0", out_src1); end
        tests++; if (out_src2 !== '0) begin fails++; $display("FAIL reset_src2 got %h exp 0", out_src2); end
    endtask

    task automatic test_basic();
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        a = rand_data();
        b = rand_data();
        out_ready = 1;
        alloc_valid = 1; alloc_ocid = 3'd3; alloc_src1_need = 1; alloc_src2_need = 1;
        step();
        drive_idle();
        tests++; if (slot_busy !== 8'h08) begin fails++; $display("FAIL basic_busy_wait got %h exp 08", slot_busy); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid got %b exp 0", out_valid); end
        rv[0] = 1; ro[0] = 4'b0011; rdat[0] = a;
        rv[2] = 1; ro[2] = 4'b1011; rdat[2] = b;
        step();
        drive_idle();
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %b exp 1", out_valid); end
        tests++; if (out_ocid !== 3'd3) begin fails++; $display("FAIL basic_ocid got %0d exp 3", out_ocid); end
        tests++; if (out_src1 !== a) begin fails++; $display("FAIL basic_src1 got %h exp %h", out_src1, a); end
        tests++; if (out_src2 !== b) begin fails++; $display("FAIL basic_src2 got %h exp %h", out_src2, b); end
        step();
        tests++; if (slot_busy[3] !== 1'b0) begin fails++; $display("FAIL basic_busy_after got %b exp 0", slot_busy[3]); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_after got %b exp 0", out_valid); end
    endtask

    task automatic test_round_robin();
        logic [DATA_W-1:0] dat [NUM_OC];
        int order [4];
        order[0] = 1; order[1] = 5; order[2] = 6; order[3] = 0;
        for (int s = 0; s < NUM_OC; s++) dat[s] = rand_data();
        do_reset();
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            drive_idle();
            alloc_valid = 1; alloc_ocid = 3'(order[3 - i]); alloc_src1_need = 1;
            step();
        end
        drive_idle();
        rv[0] = 1; ro[0] = 4'b0001; rdat[0] = dat[1];
        rv[1] = 1; ro[1] = 4'b0101; rdat[1] = dat[5];
        rv[3] = 1; ro[3] = 4'b0110; rdat[3] = dat[6];
        step();
        drive_idle();
        tests++; if (out_ocid !== 3'd1 || out_valid !== 1'b1) begin fails++; $display("FAIL rr_hold1 got v%b id%0d exp v1 id1", out_valid, out_ocid); end
        rv[2] = 1; ro[2] = 4'b0000; rdat[2] = dat[0];
        step();
        drive_idle();
        tests++; if (out_ocid !== 3'd1) begin fails++; $display("FAIL rr_hold2 got %0d exp 1", out_ocid); end
        step();
        tests++; if (out_ocid !== 3'd1) begin fails++; $display("FAIL rr_hold3 got %0d exp 1", out_ocid); end
        tests++; if (out_src1 !== dat[1]) begin fails++; $display("FAIL rr_hold_data got %h exp %h", out_src1, dat[1]); end
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            tests++; if (out_valid !== 1'b1 || out_ocid !== 3'(order[i])) begin fails++; $display("FAIL rr_order%0d got v%b id%0d exp id%0d", i, out_valid, out_ocid, order[i]); end
            tests++; if (out_src1 !== dat[order[i]] || out_src2 !== '0) begin fails++; $display("FAIL rr_data%0d got %h/%h exp %h/0", i, out_src1, out_src2, dat[order[i]]); end
            step();
        end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rr_drained got %b exp 0", out_valid); end
    endtask

    task automatic test_no_operand();
        out_ready = 0;
        drive_idle();
        alloc_valid = 1; alloc_ocid = 3'd0;
        step();
        drive_idle();
        tests++; if (out_valid !== 1'b1 || out_ocid !== 3'd0) begin fails++; $display("FAIL noop_valid got v%b id%0d exp v1 id0", out_valid, out_ocid); end
        tests++; if (out_src1 !== '0 || out_src2 !== '0) begin fails++; $display("FAIL noop_data got %h/%h exp 0/0", out_src1, out_src2); end
        out_ready = 1;
        step();
        tests++; if (out_valid !== 1'b0 || slot_busy !== 8'h00) begin fails++; $display("FAIL noop_done got v%b busy%h exp v0 busy00", out_valid, slot_busy); end
    endtask

    task automatic test_error();
        logic [DATA_W-1:0] e;
        e = rand_data();
        out_ready = 0;
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_clean got %b exp 0", err); end
        drive_idle();
        rv[1] = 1; ro[1] = 4'b0111; rdat[1] = rand_data();
        step();
        drive_idle();
        tests++; if (err !== 1'b1 || out_valid !== 1'b0 || slot_busy !== 8'h00) begin fails++; $display("FAIL err_set got err%b v%b busy%h exp err1 v0 busy00", err, out_valid, slot_busy); end
        alloc_valid = 1; alloc_ocid = 3'd7; alloc_src2_need = 1;
        step();
        drive_idle();
        rv[3] = 1; ro[3] = 4'b1111; rdat[3] = e;
        step();
        drive_idle();
        tests++; if (out_valid !== 1'b1 || out_ocid !== 3'd7) begin fails++; $display("FAIL err_recover got v%b id%0d exp v1 id7", out_valid, out_ocid); end
        tests++; if (out_src2 !== e || out_src1 !== '0) begin fails++; $display("FAIL err_recover_data got %h/%h exp 0/%h", out_src1, out_src2, e); end
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_sticky got %b exp 1", err); end
        out_ready = 1;
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1;
        drive_idle();
        alloc_valid = 1; alloc_ocid = 3'd2; alloc_src2_need = 1;
        step();
        drive_idle();
        rst = 0;
        rv[0] = 1; ro[0] = 4'b1010; rdat[0] = rand_data();
        step();
        rst = 1;
        drive_idle();
        tests++; if (slot_busy !== 8'h00 || err !== 1'b0) begin fails++; $display("FAIL rstmid_clear got busy%h err%b exp busy00 err0", slot_busy, err); end
        rv[0] = 1; ro[0] = 4'b1010; rdat[0] = rand_data();
        step();
        drive_idle();
        tests++; if (err !== 1'b1 || out_valid !== 1'b0 || slot_busy !== 8'h00) begin fails++; $display("FAIL rstmid_late got err%b v%b busy%h exp err1 v0 busy00", err, out_valid, slot_busy); end
    endtask

    task automatic test_random();
        int q_need [$];
        int q_free [$];
        int pick;
        int sel;
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            drive_idle();
            rst = (cyc % 200 == 199) ? 1'b0 : 1'b1;
            out_ready = ($urandom_range(0, 9) < 6);
            q_need.delete();
            q_free.delete();
            for (int s = 0; s < NUM_OC; s++) begin
                if (!m_alloc[s]) q_free.push_back(s);
                else if (!m_ready(s)) begin
                    if (m_n1[s] && !m_h1[s]) q_need.push_back(s * 2);
                    if (m_n2[s] && !m_h2[s]) q_need.push_back(s * 2 + 1);
                end
            end
            if ($urandom_range(0, 9) < 4) begin
                alloc_valid = 1;
                if (q_free.size() > 0 && $urandom_range(0, 9) != 0)
                    alloc_ocid = 3'(q_free[$urandom_range(0, q_free.size() - 1)]);
                else
                    alloc_ocid = 3'($urandom_range(0, 7));
                alloc_src1_need = 1'($urandom_range(0, 1));
                alloc_src2_need = 1'($urandom_range(0, 1));
            end
            for (int b = 0; b < 4; b++) begin
                rv[b] = ($urandom_range(0, 9) < 4);
                rdat[b] = rand_data();
                if (q_need.size() > 0 && $urandom_range(0, 24) != 0) begin
                    pick = q_need[$urandom_range(0, q_need.size() - 1)];
                    ro[b] = {1'(pick % 2), 3'(pick / 2)};
                end else begin
                    ro[b] = 4'($urandom_range(0, 15));
                end
            end
            step();
            sel = m_sel();
            tests++; if (out_valid !== (sel >= 0)) begin fails++; $display("FAIL rnd_valid cyc%0d got %b exp %b", cyc, out_valid, sel >= 0); end
            if (sel >= 0) begin
                tests++; if (out_ocid !== 3'(sel)) begin fails++; $display("FAIL rnd_ocid cyc%0d got %0d exp %0d", cyc, out_ocid, sel); end
                tests++; if (out_src1 !== m_d1[sel]) begin fails++; $display("FAIL rnd_src1 cyc%0d got %h exp %h", cyc, out_src1, m_d1[sel]); end
                tests++; if (out_src2 !== m_d2[sel]) begin fails++; $display("FAIL rnd_src2 cyc%0d got %h exp %h", cyc, out_src2, m_d2[sel]); end
            end
            tests++; if (slot_busy !== m_busy()) begin fails++; $display("FAIL rnd_busy cyc%0d got %h exp %h", cyc, slot_busy, m_busy()); end
            tests++; if (err !== m_err) begin fails++; $display("FAIL rnd_err cyc%0d got %b exp %b", cyc, err, m_err); end
        end
        rst = 1;
    endtask

    initial begin
        rst = 0;
        out_ready = 0;
        drive_idle();
        model_reset();
        test_reset();
        test_basic();
        test_round_robin();
        test_no_operand();
        test_error();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
